// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one block-RAM port between an instruction-fetch requester and a
// load/store requester. Only one access is in flight at a time.
// Arbitration is round-robin and the grant is a pure function of the two
// valids and the last grant. The block places store bytes on the RAM lanes
// and extracts, sign-extends or zero-extends load data (little-endian).
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   if_req_valid/ready    : fetch request handshake, if_addr word address
//   if_resp_valid, if_rdata : one-cycle fetch response with the full word
//   d_req_valid/ready     : data request handshake with d_addr, d_we,
//                           d_size, d_signed and d_wdata
//   d_resp_valid, d_rdata, d_misaligned : one-cycle data response
//   mem_en/we/addr/din    : registered RAM controls
//   mem_dout              : RAM read data, valid READ_LATENCY cycles after
//                           the edge that samples mem_en
module mem_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_rdata,
    output logic        d_misaligned,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic        cur_data_q, cur_data_d;     // 1 = data transaction in flight
    logic        cur_we_q, cur_we_d;
    logic [1:0]  cur_off_q, cur_off_d;
    logic [1:0]  cur_size_q, cur_size_d;
    logic        cur_signed_q, cur_signed_d;
    logic        mem_en_q, mem_en_d;
    logic [3:0]  mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic        if_resp_q, if_resp_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_resp_q, d_resp_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_mis_q, d_mis_d;

    // Fetch addresses are word aligned by contract; the low bits are dropped.
    logic unused_if_low;
    assign unused_if_low = ^if_addr[1:0];

    // Grant: a lone requester wins; on a tie the one not granted last wins.
    logic idle, pick_if, pick_d, if_acc, d_acc;
    assign idle    = (state_q == S_IDLE) && !rst;
    assign pick_if = if_req_valid && (!d_req_valid || last_grant_q == GNT_D);
    assign pick_d  = d_req_valid && (!if_req_valid || last_grant_q == GNT_IF);
    assign if_req_ready = idle && pick_if;
    assign d_req_ready  = idle && pick_d;
    assign if_acc = if_req_valid && if_req_ready;
    assign d_acc  = d_req_valid && d_req_ready;

    logic misaligned;
    always_comb begin
        case (d_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = d_addr[0];
            2'b10:   misaligned = |d_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Store lane placement: data is replicated so the RAM only needs the
    // byte enables to select the target lanes.
    logic [3:0]  st_we;
    logic [31:0] st_din;
    always_comb begin
        case (d_size)
            2'b00: begin
                st_we  = 4'b0001 << d_addr[1:0];
                st_din = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                st_we  = d_addr[1] ? 4'b1100 : 4'b0011;
                st_din = {2{d_wdata[15:0]}};
            end
            default: begin
                st_we  = 4'b1111;
                st_din = d_wdata;
            end
        endcase
    end

    // Load extraction: halves are aligned, so shifting by the byte offset
    // brings either a byte or a half down to bit 0.
    logic [31:0] ld_shift, ld_val;
    assign ld_shift = mem_dout >> {cur_off_q, 3'b000};
    always_comb begin
        case (cur_size_q)
            2'b00:   ld_val = cur_signed_q ? {{24{ld_shift[7]}}, ld_shift[7:0]}
                                           : {24'd0, ld_shift[7:0]};
            2'b01:   ld_val = cur_signed_q ? {{16{ld_shift[15]}}, ld_shift[15:0]}
                                           : {16'd0, ld_shift[15:0]};
            default: ld_val = mem_dout;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        cur_data_d   = cur_data_q;
        cur_we_d     = cur_we_q;
        cur_off_d    = cur_off_q;
        cur_size_d   = cur_size_q;
        cur_signed_d = cur_signed_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 4'b0000;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        if_resp_d    = 1'b0;
        if_rdata_d   = 32'd0;
        d_resp_d     = 1'b0;
        d_rdata_d    = 32'd0;
        d_mis_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_acc) begin
                    last_grant_d = GNT_IF;
                    state_d      = S_ISSUE;
                    mem_en_d     = 1'b1;
                    mem_addr_d   = {if_addr[31:2], 2'b00};
                    mem_din_d    = 32'd0;
                    cur_data_d   = 1'b0;
                    cur_we_d     = 1'b0;
                end else if (d_acc) begin
                    last_grant_d = GNT_D;
                    if (misaligned) begin
                        // Rejected without touching the RAM; stay in IDLE.
                        d_resp_d = 1'b1;
                        d_mis_d  = 1'b1;
                    end else begin
                        state_d      = S_ISSUE;
                        mem_en_d     = 1'b1;
                        mem_addr_d   = {d_addr[31:2], 2'b00};
                        mem_we_d     = d_we ? st_we : 4'b0000;
                        mem_din_d    = d_we ? st_din : 32'd0;
                        cur_data_d   = 1'b1;
                        cur_we_d     = d_we;
                        cur_off_d    = d_addr[1:0];
                        cur_size_d   = d_size;
                        cur_signed_d = d_signed;
                    end
                end
            end
            S_ISSUE: begin
                if (cur_data_q && cur_we_q) begin
                    state_d  = S_IDLE;
                    d_resp_d = 1'b1;
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 3'd0;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = 3'd0;
                    if (cur_data_q) begin
                        d_resp_d  = 1'b1;
                        d_rdata_d = ld_val;
                    end else begin
                        if_resp_d  = 1'b1;
                        if_rdata_d = mem_dout;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_D;
            wait_cnt_q   <= 3'd0;
            cur_data_q   <= 1'b0;
            cur_we_q     <= 1'b0;
            cur_off_q    <= 2'd0;
            cur_size_q   <= 2'd0;
            cur_signed_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 4'd0;
            mem_addr_q   <= 32'd0;
            mem_din_q    <= 32'd0;
            if_resp_q    <= 1'b0;
            if_rdata_q   <= 32'd0;
            d_resp_q     <= 1'b0;
            d_rdata_q    <= 32'd0;
            d_mis_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            cur_data_q   <= cur_data_d;
            cur_we_q     <= cur_we_d;
            cur_off_q    <= cur_off_d;
            cur_size_q   <= cur_size_d;
            cur_signed_q <= cur_signed_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            if_resp_q    <= if_resp_d;
            if_rdata_q   <= if_rdata_d;
            d_resp_q     <= d_resp_d;
            d_rdata_q    <= d_rdata_d;
            d_mis_q      <= d_mis_d;
        end
    end

    assign mem_en        = mem_en_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_din       = mem_din_q;
    assign if_resp_valid = if_resp_q;
    assign if_rdata      = if_rdata_q;
    assign d_resp_valid  = d_resp_q;
    assign d_rdata       = d_rdata_q;
    assign d_misaligned  = d_mis_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter at READ_LATENCY=1 with a small
// byte-writable RAM model that has a one-cycle registered read.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_signed;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_resp_valid, d_misaligned;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_din, mem_dout;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_size(d_size), .d_signed(d_signed), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_misaligned(d_misaligned),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int k = 0; k < 4; k++)
                if (mem_we[k]) ram[mem_addr[9:2]][8*k +: 8] <= mem_din[8*k +: 8];
            mem_dout <= ram[mem_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " if_ready"}, {31'd0, if_req_ready}, 0);
        chk({tag, " d_ready"}, {31'd0, d_req_ready}, 0);
        chk({tag, " mem_en"}, {31'd0, mem_en}, 0);
        chk({tag, " mem_we"}, {28'd0, mem_we}, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_din"}, mem_din, 0);
        chk({tag, " resp"}, {30'd0, if_resp_valid, d_resp_valid}, 0);
        chk({tag, " rdata"}, if_rdata | d_rdata, 0);
        chk({tag, " mis"}, {31'd0, d_misaligned}, 0);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data, input string tag);
        int n;
        bit got;
        if_addr = addr;
        if_req_valid = 1'b1;
        @(negedge clk);
        chk({tag, " ready"}, {31'd0, if_req_ready}, 1);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        n = 0;
        got = 0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, " mem_en"}, {31'd0, mem_en}, 1);
                chk({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                chk({tag, " mem_we"}, {28'd0, mem_we}, 0);
            end
            if (if_resp_valid) begin
                got = 1;
                chk({tag, " latency"}, n, 3);
                chk({tag, " rdata"}, if_rdata, exp_data);
            end
        end
        if (!got) chk({tag, " resp timeout"}, 0, 1);
        @(negedge clk);
        chk({tag, " pulse width"}, {31'd0, if_resp_valid}, 0);
        @(posedge clk); #1;
        $display("fetch %s addr=%h rdata=%h", tag, addr, if_rdata);
    endtask

    task automatic data_txn(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int exp_lat, input logic [31:0] exp_rdata, input logic exp_mis,
                            input logic [3:0] exp_we, input logic [31:0] exp_din, input string tag);
        int n;
        bit got, en_seen;
        d_we = we; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wdata;
        d_req_valid = 1'b1;
        @(negedge clk);
        chk({tag, " ready"}, {31'd0, d_req_ready}, 1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        n = 0;
        got = 0;
        en_seen = 0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (mem_en) en_seen = 1;
            if (n == 1 && !exp_mis) begin
                chk({tag, " mem_en"}, {31'd0, mem_en}, 1);
                chk({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                chk({tag, " mem_we"}, {28'd0, mem_we}, {28'd0, exp_we});
                if (we) chk({tag, " mem_din"}, mem_din, exp_din);
            end
            if (d_resp_valid) begin
                got = 1;
                chk({tag, " latency"}, n, exp_lat);
                chk({tag, " rdata"}, d_rdata, exp_rdata);
                chk({tag, " misaligned"}, {31'd0, d_misaligned}, {31'd0, exp_mis});
            end
        end
        if (!got) chk({tag, " resp timeout"}, 0, 1);
        if (exp_mis) chk({tag, " no mem_en"}, {31'd0, en_seen}, 0);
        @(negedge clk);
        chk({tag, " pulse width"}, {31'd0, d_resp_valid}, 0);
        @(posedge clk); #1;
        $display("data %s addr=%h rdata=%h mis=%0d", tag, addr, d_rdata, d_misaligned);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int gcyc [4];
        bit gwho [4];
        int ng, cyc;

        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        ram[4] = 32'h11223344;   // byte address 0x10
        mem_dout = 32'd0;
        rst = 1'b1;
        if_req_valid = 1'b1; if_addr = 32'h10;
        d_req_valid = 1'b1; d_addr = 32'h100; d_we = 1'b0; d_size = 2'b10;
        d_signed = 1'b0; d_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        $display("reset outputs checked");
        #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // Basic fetch; low address bits are ignored.
        fetch(32'h10, 32'h11223344, "if_0x10");
        fetch(32'h13, 32'h11223344, "if_0x13");

        // Byte and half stores followed by loads of both signednesses.
        data_txn(1, 2'b00, 0, 32'h103, 32'h000000AB, 2, 0, 0, 4'b1000, 32'hABABABAB, "sb_0x103");
        data_txn(0, 2'b00, 0, 32'h103, 0, 3, 32'h000000AB, 0, 4'b0000, 0, "lbu_0x103");
        data_txn(0, 2'b00, 1, 32'h103, 0, 3, 32'hFFFFFFAB, 0, 4'b0000, 0, "lb_0x103");
        data_txn(1, 2'b01, 0, 32'h102, 32'h00008001, 2, 0, 0, 4'b1100, 32'h80018001, "sh_0x102");
        data_txn(0, 2'b01, 1, 32'h102, 0, 3, 32'hFFFF8001, 0, 4'b0000, 0, "lh_0x102");
        data_txn(0, 2'b01, 0, 32'h102, 0, 3, 32'h00008001, 0, 4'b0000, 0, "lhu_0x102");
        data_txn(1, 2'b01, 0, 32'h108, 32'h0000BEEF, 2, 0, 0, 4'b0011, 32'hBEEFBEEF, "sh_0x108");
        data_txn(1, 2'b00, 0, 32'h10D, 32'h0000007F, 2, 0, 0, 4'b0010, 32'h7F7F7F7F, "sb_0x10d");
        data_txn(0, 2'b00, 1, 32'h10D, 0, 3, 32'h0000007F, 0, 4'b0000, 0, "lb_0x10d");
        data_txn(1, 2'b10, 0, 32'h104, 32'hDEADBEEF, 2, 0, 0, 4'b1111, 32'hDEADBEEF, "sw_0x104");
        data_txn(0, 2'b10, 1, 32'h104, 0, 3, 32'hDEADBEEF, 0, 4'b0000, 0, "lw_0x104");
        data_txn(0, 2'b01, 1, 32'h106, 0, 3, 32'hFFFFDEAD, 0, 4'b0000, 0, "lh_0x106");

        // Misaligned accesses: response next cycle, no RAM access.
        data_txn(0, 2'b10, 0, 32'h106, 0, 1, 0, 1, 4'b0000, 0, "lw_0x106");
        data_txn(1, 2'b01, 0, 32'h101, 32'h1234, 1, 0, 1, 4'b0000, 0, "sh_0x101");
        data_txn(0, 2'b11, 0, 32'h100, 0, 1, 0, 1, 4'b0000, 0, "rsvd_size");
        data_txn(0, 2'b10, 0, 32'h104, 0, 3, 32'hDEADBEEF, 0, 4'b0000, 0, "lw_after_mis");

        // Contention right after reset: fetch wins first, then alternation.
        do_reset();
        if_addr = 32'h10;
        d_addr = 32'h104; d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0;
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        ng = 0;
        cyc = 0;
        while (ng < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if_req_ready && d_req_ready) chk("both ready", 1, 0);
            if (if_req_ready || d_req_ready) begin
                gwho[ng] = d_req_ready;
                gcyc[ng] = cyc;
                $display("grant %0d to %s at cycle %0d", ng, d_req_ready ? "D" : "IF", cyc);
                ng++;
            end
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        chk("grant count", ng, 4);
        for (int i = 0; i < ng; i++)
            chk($sformatf("grant %0d owner", i), {31'd0, gwho[i]}, i % 2);
        if (ng >= 2) chk("b2b spacing", gcyc[1] - gcyc[0], 3);
        repeat (6) @(posedge clk);
        #1;

        // Reset while waiting for read data: the response is dropped.
        if_addr = 32'h10;
        if_req_valid = 1'b1;
        @(negedge clk);
        chk("rst_wait ready", {31'd0, if_req_ready}, 1);
        @(posedge clk); #1 if_req_valid = 1'b0;   // ISSUE cycle
        @(posedge clk); #1 rst = 1'b1;            // WAIT cycle
        @(negedge clk);
        chk("rst_wait ready low", {31'd0, if_req_ready | d_req_ready}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_rst");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no dropped resp", {30'd0, if_resp_valid, d_resp_valid}, 0);
        end
        $display("reset during wait checked");
        @(posedge clk); #1;
        fetch(32'h10, 32'h11223344, "if_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end
endmodule
